// File: rtl/riscv_bp_pkg.sv
// Shared branch-prediction definitions used by fetch, decode and the predictor.
// Counter encodings order from strongest not-taken to strongest taken.
package riscv_bp_pkg;

    localparam int         ADDR_W_DEF = 5;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        SN = 2'b00,
        WN = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } bp_cnt_e;

endpackage

// File: rtl/bp_sat_counter_next.sv
// Next-state and predict bit for one 2-bit saturating direction counter.
module bp_sat_counter_next
    import riscv_bp_pkg::*;
(
    input  logic [1:0] i_state,
    input  logic       i_taken,
    output logic [1:0] o_next,
    output logic       o_predict
);

    always_comb begin
        o_next = i_state;
        if (i_taken) begin
            if (i_state != ST) o_next = i_state + 2'd1;
        end else begin
            if (i_state != SN) o_next = i_state - 2'd1;
        end
    end

    assign o_predict = (i_state == WT) || (i_state == ST);

endmodule

// File: rtl/branch_target_predictor.sv
// Per-address direction/target predictor with registered mispredict flush and
// saturating branch/mispredict counters for the debug display.
module branch_target_predictor
    import riscv_bp_pkg::*;
#(
    parameter int         ADDR_W    = ADDR_W_DEF,
    parameter int         ENTRIES   = 32,
    parameter logic [1:0] CNT_RESET = 2'b01,
    parameter int         PERF_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_lookup_valid,
    input  logic [ADDR_W-1:0] i_lookup_pc,
    input  logic [6:0]        i_lookup_opcode,
    input  logic [ADDR_W-1:0] i_lookup_offset,
    output logic              o_pred_taken,
    output logic [ADDR_W-1:0] o_pred_target,
    input  logic              i_resolve_valid,
    input  logic [ADDR_W-1:0] i_resolve_pc,
    input  logic              i_resolve_taken,
    input  logic [ADDR_W-1:0] i_resolve_target,
    input  logic              i_resolve_pred,
    input  logic [ADDR_W-1:0] i_resolve_pred_tgt,
    output logic              o_flush,
    output logic [ADDR_W-1:0] o_redirect_pc,
    output logic [PERF_W-1:0] o_branch_count,
    output logic [PERF_W-1:0] o_mispredict_count
);

    logic [1:0]        r_cnt     [ENTRIES];
    logic [ADDR_W-1:0] r_btb_tgt [ENTRIES];
    logic [ENTRIES-1:0] r_btb_valid;
    logic              r_flush;
    logic [ADDR_W-1:0] r_redirect_pc;
    logic [PERF_W-1:0] r_branch_count;
    logic [PERF_W-1:0] r_mispredict_count;

    logic [1:0]         w_cnt_next [ENTRIES];
    logic [ENTRIES-1:0] w_cnt_pred;
    logic               w_is_branch;
    logic               w_mispredict;
    logic [ADDR_W-1:0]  w_offset_tgt;

    // Every entry computes its own next state so the lookup side can reuse the predict bit.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
        bp_sat_counter_next u_cnt_next (
            .i_state   (r_cnt[g]),
            .i_taken   (i_resolve_taken),
            .o_next    (w_cnt_next[g]),
            .o_predict (w_cnt_pred[g])
        );
    end

    assign w_is_branch  = i_lookup_valid && (i_lookup_opcode == OPC_BRANCH);
    assign w_offset_tgt = i_lookup_pc + i_lookup_offset;
    assign o_pred_taken = w_is_branch && w_cnt_pred[i_lookup_pc];

    always_comb begin
        o_pred_target = i_lookup_pc + ADDR_W'(1);
        if (o_pred_taken)
            o_pred_target = r_btb_valid[i_lookup_pc] ? r_btb_tgt[i_lookup_pc] : w_offset_tgt;
    end

    assign w_mispredict = i_resolve_valid &&
                          ((i_resolve_taken != i_resolve_pred) ||
                           (i_resolve_taken && i_resolve_pred &&
                            (i_resolve_target != i_resolve_pred_tgt)));

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_RESET;
            r_btb_valid        <= '0;
            r_flush            <= 1'b0;
            r_redirect_pc      <= '0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            r_flush <= w_mispredict;
            if (i_resolve_valid) begin
                for (int i = 0; i < ENTRIES; i++)
                    if (i_resolve_pc == ADDR_W'(i)) r_cnt[i] <= w_cnt_next[i];
                if (i_resolve_taken) r_btb_valid[i_resolve_pc] <= 1'b1;
                if (r_branch_count != {PERF_W{1'b1}})
                    r_branch_count <= r_branch_count + PERF_W'(1);
            end
            if (w_mispredict) begin
                r_redirect_pc <= i_resolve_taken ? i_resolve_target : i_resolve_pc + ADDR_W'(1);
                if (r_mispredict_count != {PERF_W{1'b1}})
                    r_mispredict_count <= r_mispredict_count + PERF_W'(1);
            end
        end
    end

    // Targets are only meaningful behind their valid bit, so they need no reset.
    always_ff @(posedge i_clk) begin
        if (i_reset && i_resolve_valid && i_resolve_taken)
            r_btb_tgt[i_resolve_pc] <= i_resolve_target;
    end

    assign o_flush            = r_flush;
    assign o_redirect_pc      = r_redirect_pc;
    assign o_branch_count     = r_branch_count;
    assign o_mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomized and directed bench for branch_target_predictor against a behavioural model.
module tb_branch_target_predictor;

    logic       clk;
    logic       reset;
    logic       lookup_valid;
    logic [4:0] lookup_pc;
    logic [6:0] lookup_opcode;
    logic [4:0] lookup_offset;
    logic       pred_taken;
    logic [4:0] pred_target;
    logic       resolve_valid;
    logic [4:0] resolve_pc;
    logic       resolve_taken;
    logic [4:0] resolve_target;
    logic       resolve_pred;
    logic [4:0] resolve_pred_tgt;
    logic       flush;
    logic [4:0] redirect_pc;
    logic [7:0] branch_count;
    logic [7:0] mispredict_count;

    branch_target_predictor dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_lookup_valid     (lookup_valid),
        .i_lookup_pc        (lookup_pc),
        .i_lookup_opcode    (lookup_opcode),
        .i_lookup_offset    (lookup_offset),
        .o_pred_taken       (pred_taken),
        .o_pred_target      (pred_target),
        .i_resolve_valid    (resolve_valid),
        .i_resolve_pc       (resolve_pc),
        .i_resolve_taken    (resolve_taken),
        .i_resolve_target   (resolve_target),
        .i_resolve_pred     (resolve_pred),
        .i_resolve_pred_tgt (resolve_pred_tgt),
        .o_flush            (flush),
        .o_redirect_pc      (redirect_pc),
        .o_branch_count     (branch_count),
        .o_mispredict_count (mispredict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: counter strength 0..3, plain target table, plain perf counts.
    int m_cnt   [32];
    bit m_valid [32];
    int m_tgt   [32];
    int m_flush;
    int m_redir;
    int m_bc;
    int m_mc;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int mis;
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                m_cnt[i]   = 1;
                m_valid[i] = 1'b0;
            end
            m_flush = 0;
            m_redir = 0;
            m_bc    = 0;
            m_mc    = 0;
        end else begin
            m_flush = 0;
            if (resolve_valid) begin
                mis = ((resolve_taken != resolve_pred) ||
                       (resolve_taken && resolve_pred && resolve_target != resolve_pred_tgt)) ? 1 : 0;
                if (resolve_taken) begin
                    m_cnt[resolve_pc]   = (m_cnt[resolve_pc] < 3) ? m_cnt[resolve_pc] + 1 : 3;
                    m_valid[resolve_pc] = 1'b1;
                    m_tgt[resolve_pc]   = int'(resolve_target);
                end else begin
                    m_cnt[resolve_pc] = (m_cnt[resolve_pc] > 0) ? m_cnt[resolve_pc] - 1 : 0;
                end
                m_bc = (m_bc < 255) ? m_bc + 1 : 255;
                if (mis != 0) begin
                    m_mc    = (m_mc < 255) ? m_mc + 1 : 255;
                    m_flush = 1;
                    m_redir = resolve_taken ? int'(resolve_target) : (int'(resolve_pc) + 1) % 32;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_lookup(input logic v, input int pc, input logic [6:0] op, input int off);
        lookup_valid  = v;
        lookup_pc     = 5'(pc);
        lookup_opcode = op;
        lookup_offset = 5'(off);
    endtask

    task automatic drive_resolve(input logic v, input int pc, input logic t, input int tgt,
                                 input logic p, input int ptgt);
        resolve_valid    = v;
        resolve_pc       = 5'(pc);
        resolve_taken    = t;
        resolve_target   = 5'(tgt);
        resolve_pred     = p;
        resolve_pred_tgt = 5'(ptgt);
    endtask

    // Every cycle: outputs against the model, sampled mid-cycle.
    always @(negedge clk) begin
        int exp_pt;
        int exp_tg;
        if (chk_en) begin
            exp_pt = (lookup_valid && lookup_opcode == 7'b1100011 && m_cnt[lookup_pc] >= 2) ? 1 : 0;
            if (exp_pt != 0)
                exp_tg = m_valid[lookup_pc] ? m_tgt[lookup_pc]
                                            : (int'(lookup_pc) + int'(lookup_offset)) % 32;
            else
                exp_tg = (int'(lookup_pc) + 1) % 32;
            check("pred_taken", int'(pred_taken), exp_pt);
            check("pred_target", int'(pred_target), exp_tg);
            check("flush", int'(flush), m_flush);
            if (m_flush != 0) check("redirect_pc", int'(redirect_pc), m_redir);
            check("branch_count", int'(branch_count), m_bc);
            check("mispredict_count", int'(mispredict_count), m_mc);
        end
    end

    localparam logic [6:0] BR = 7'b1100011;

    initial begin
        reset = 1'b0;
        drive_lookup(1'b0, 0, 7'd0, 0);
        drive_resolve(1'b0, 0, 1'b0, 0, 1'b0, 0);
        tick();
        chk_en = 1'b1;
        reset  = 1'b1;

        // Reset state: nothing predicts taken
        for (int pc = 0; pc < 32; pc++) begin
            drive_lookup(1'b1, pc, BR, 3);
            #1 check("reset_pred", int'(pred_taken), 0);
            tick();
        end
        check("reset_bc", int'(branch_count), 0);
        check("reset_flush", int'(flush), 0);

        // Training pc=4 twice taken to 9
        drive_lookup(1'b0, 0, 7'd0, 0);
        drive_resolve(1'b1, 4, 1'b1, 9, 1'b1, 9);
        tick();
        tick();
        drive_resolve(1'b0, 0, 1'b0, 0, 1'b0, 0);
        drive_lookup(1'b1, 4, BR, 5);
        #1 check("train_pred", int'(pred_taken), 1);
        check("train_tgt", int'(pred_target), 9);
        tick();

        // Saturation at pc=7
        drive_lookup(1'b1, 7, BR, 1);
        drive_resolve(1'b1, 7, 1'b1, 20, 1'b1, 20);
        for (int k = 0; k < 5; k++) tick();
        drive_resolve(1'b1, 7, 1'b0, 0, 1'b0, 0);
        tick();
        drive_resolve(1'b0, 0, 1'b0, 0, 1'b0, 0);
        #1 check("sat_wt_pred", int'(pred_taken), 1);
        drive_resolve(1'b1, 7, 1'b0, 0, 1'b0, 0);
        tick();
        drive_resolve(1'b0, 0, 1'b0, 0, 1'b0, 0);
        #1 check("sat_wn_pred", int'(pred_taken), 0);
        check("sat_wn_tgt", int'(pred_target), 8);

        // Direction mispredict, then wrap redirect
        drive_resolve(1'b1, 3, 1'b1, 12, 1'b0, 0);
        tick();
        drive_resolve(1'b0, 0, 1'b0, 0, 1'b0, 0);
        #1 check("mis_flush", int'(flush), 1);
        check("mis_redirect", int'(redirect_pc), 12);
        tick();
        #1 check("mis_flush_one", int'(flush), 0);
        drive_resolve(1'b1, 31, 1'b0, 0, 1'b1, 4);
        tick();
        drive_resolve(1'b0, 0, 1'b0, 0, 1'b0, 0);
        #1 check("wrap_flush", int'(flush), 1);
        check("wrap_redirect", int'(redirect_pc), 0);
        tick();

        // Target mismatch at pc=10
        drive_resolve(1'b1, 10, 1'b1, 6, 1'b1, 5);
        tick();
        drive_resolve(1'b0, 0, 1'b0, 0, 1'b0, 0);
        drive_lookup(1'b1, 10, BR, 1);
        #1 check("tgt_flush", int'(flush), 1);
        check("tgt_redirect", int'(redirect_pc), 6);
        check("tgt_btb", int'(pred_target), 6);
        tick();

        // Same-index lookup and resolve: lookup sees the old counter
        drive_lookup(1'b1, 2, BR, 1);
        drive_resolve(1'b1, 2, 1'b1, 20, 1'b1, 20);
        #1 check("coll_old_pred", int'(pred_taken), 0);
        check("coll_old_tgt", int'(pred_target), 3);
        tick();
        drive_resolve(1'b0, 0, 1'b0, 0, 1'b0, 0);
        #1 check("coll_new_tgt", int'(pred_target), 20);

        // Reset with a mispredict in the same cycle
        drive_resolve(1'b1, 5, 1'b1, 1, 1'b0, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        drive_resolve(1'b0, 0, 1'b0, 0, 1'b0, 0);
        #1 check("rst_mid_flush", int'(flush), 0);
        check("rst_mid_pred", int'(pred_taken), 0);
        check("rst_mid_bc", int'(branch_count), 0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            drive_lookup($urandom_range(0, 3) != 0, $urandom_range(0, 31),
                         ($urandom_range(0, 1) != 0) ? BR : 7'($urandom),
                         $urandom_range(0, 31));
            drive_resolve($urandom_range(0, 2) != 0,
                          ($urandom_range(0, 3) == 0) ? int'(lookup_pc) : $urandom_range(0, 7),
                          $urandom_range(0, 1) != 0, $urandom_range(0, 31),
                          $urandom_range(0, 1) != 0, 0);
            resolve_pred_tgt = ($urandom_range(0, 1) != 0) ? resolve_target : 5'($urandom);
            tick();
        end
        reset = 1'b1;

        // Perf counters saturate at 255
        drive_lookup(1'b0, 0, 7'd0, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int n = 0; n < 300; n++) begin
            drive_resolve(1'b1, n % 32, 1'b1, 1, 1'b0, 0);
            tick();
        end
        drive_resolve(1'b0, 0, 1'b0, 0, 1'b0, 0);
        #1 check("perf_bc_sat", int'(branch_count), 255);
        check("perf_mc_sat", int'(mispredict_count), 255);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
